// File: rtl/swap_pair_feeder.sv
// Groups a valid/ready word stream into pairs for the registered compare/swap stage,
// strobes each pair on a/b with en, and tracks per-frame pair counts.
module swap_pair_feeder #(
  parameter int                 width     = 8,
  parameter logic [width-1:0]   PAD_VALUE = '0,
  parameter int                 CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [width-1:0] a,
  output logic [width-1:0] b,
  output logic             en,
  output logic             res_valid,
  output logic             res_last,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] frame_pairs
);

  typedef enum logic [1:0] {FIRST, SECOND, ISSUE} state_t;

  state_t state, state_nxt;
  logic   xfer;
  logic   last_q;

  assign xfer = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FIRST;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FIRST:   if (xfer) state_nxt = in_last ? ISSUE : SECOND;
      SECOND:  if (xfer) state_nxt = ISSUE;
      ISSUE:   state_nxt = FIRST;
      default: state_nxt = FIRST;
    endcase
  end

  // Ready depends only on the registered state, never on in_valid.
  always_comb begin
    in_ready = (state != ISSUE);
  end

  // en is a flop so the swap stage sees a clean strobe for exactly the ISSUE cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a      <= '0;
      b      <= '0;
      last_q <= 1'b0;
      en     <= 1'b0;
    end else begin
      en <= (state_nxt == ISSUE);
      case (state)
        FIRST: if (xfer) begin
          a <= in_data;
          if (in_last) begin
            b      <= PAD_VALUE;
            last_q <= 1'b1;
          end
        end
        SECOND: if (xfer) begin
          b      <= in_data;
          last_q <= in_last;
        end
        ISSUE:   last_q <= 1'b0;
        default: last_q <= 1'b0;
      endcase
    end
  end

  // Results line up with the cycle the swap stage's outputs reflect the issued pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid   <= 1'b0;
      res_last    <= 1'b0;
      pair_count  <= '0;
      frame_pairs <= '0;
    end else begin
      res_valid <= en;
      res_last  <= en & last_q;
      if (en) begin
        if (last_q) begin
          frame_pairs <= pair_count + 1'b1;
          pair_count  <= '0;
        end else begin
          pair_count  <= pair_count + 1'b1;
        end
      end
    end
  end

endmodule
